// File: rtl/music_pkg.sv
// music_pkg: shared definitions for the song sequencer and its helpers.
//   - note/duration/beat field widths
//   - bit positions of the fields inside a 16-bit song ROM entry
//   - entry type constants (bit 15 selects note vs. wait)
//   - sequencer state encodings
package music_pkg;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;
  localparam int unsigned BEAT_W = 6;

  // Entry layout
  //   note entry : [15]=0, note=[14:9], duration=[8:3], [2:0] unused
  //   wait entry : [15]=1, beats=[5:0], [14:6] unused
  localparam int unsigned ENTRY_TYPE_BIT = 15;
  localparam int unsigned NOTE_MSB       = 14;
  localparam int unsigned NOTE_LSB       = 9;
  localparam int unsigned DUR_MSB        = 8;
  localparam int unsigned DUR_LSB        = 3;
  localparam int unsigned BEATS_MSB      = 5;
  localparam int unsigned BEATS_LSB      = 0;

  localparam logic ENTRY_NOTE = 1'b0;
  localparam logic ENTRY_WAIT = 1'b1;

  // Sequencer state encodings
  localparam logic [2:0] ST_FETCH    = 3'd0;
  localparam logic [2:0] ST_ROMWAIT  = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_ISSUE    = 3'd3;
  localparam logic [2:0] ST_WAITBEAT = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/song_sequencer_beat_countdown.sv
// beat_countdown: 6-bit beat down-counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load value (has priority over counting)
//   value      : value to load
//   beat       : single-cycle beat tick
//   play       : beats only count while play is high
//   zero       : count is zero
// The counter saturates at zero, so stray beats outside a wait are harmless.
module beat_countdown
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BEAT_W-1:0] value,
  input  logic              beat,
  input  logic              play,
  output logic              zero
);

  logic [BEAT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (beat && play && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks one song in an external synchronous ROM and drives
// the note-load side of the note distributor.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   play              : 1 = advance, 0 = pause (gates new fetches and beats)
//   beat              : single-cycle beat tick
//   song              : song select
//   rom_addr          : {song, index} to the song ROM
//   rom_data          : ROM word, valid one cycle after rom_addr
//   load_new_note     : single-cycle note-load strobe
//   note_to_load      : note code (last issued value held between strobes)
//   duration_to_load  : duration in beats (held like note_to_load)
//   song_done         : song finished
// Build option SONG_SEQUENCER_LOOP_EN: when defined, the end of a song wraps
// to entry 0 and song_done pulses for one cycle; otherwise DONE is terminal
// and song_done is sticky until reset or a song change.
module song_sequencer
  import music_pkg::*;
#(
  parameter int unsigned SONG_BITS  = 2,
  parameter int unsigned ENTRY_BITS = 5,
  parameter int unsigned ROM_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          beat,
  input  logic [SONG_BITS-1:0]          song,
  output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]          rom_data,
  output logic                          load_new_note,
  output logic [NOTE_W-1:0]             note_to_load,
  output logic [DUR_W-1:0]              duration_to_load,
  output logic                          song_done
);

  logic [2:0]            state_q, state_d;
  logic [ENTRY_BITS-1:0] index_q, index_d;
  logic [SONG_BITS-1:0]  song_q, song_d;
  logic                  done_q, done_d;
  logic [NOTE_W-1:0]     pend_note_q, pend_note_d;
  logic [DUR_W-1:0]      pend_dur_q, pend_dur_d;
  logic [NOTE_W-1:0]     last_note_q, last_note_d;
  logic [DUR_W-1:0]      last_dur_q, last_dur_d;

  logic              cnt_load;
  logic [BEAT_W-1:0] cnt_value;
  logic              cnt_zero;

  logic [15:0]       rom_word;
  logic              unused_rom_bits;
  logic              song_chg;
  logic              issue_fire;
  logic              advance;
  logic              end_song;
  logic [BEAT_W-1:0] word_beats;

  assign rom_word        = rom_data[15:0];
  assign unused_rom_bits = ^rom_word[2:0];
  assign word_beats      = rom_word[BEATS_MSB:BEATS_LSB];
  assign song_chg        = (song != song_q);

  // The strobe is gated combinationally so that a reset or song change
  // arriving during ISSUE suppresses it in that very cycle.
  assign issue_fire = (state_q == ST_ISSUE) && !song_chg && !reset;

  beat_countdown u_beat_countdown (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .beat  (beat),
    .play  (play),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    song_d      = song;
    pend_note_d = pend_note_q;
    pend_dur_d  = pend_dur_q;
    last_note_d = last_note_q;
    last_dur_d  = last_dur_q;
`ifdef SONG_SEQUENCER_LOOP_EN
    done_d      = 1'b0;
`else
    done_d      = done_q;
`endif
    cnt_load    = 1'b0;
    cnt_value   = '0;
    advance     = 1'b0;
    end_song    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (play) begin
          state_d = ST_ROMWAIT;
        end
      end
      ST_ROMWAIT: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        pend_note_d = rom_word[NOTE_MSB:NOTE_LSB];
        pend_dur_d  = rom_word[DUR_MSB:DUR_LSB];
        if (rom_word[ENTRY_TYPE_BIT] != ENTRY_WAIT) begin
          state_d = ST_ISSUE;
        end else if (word_beats != '0) begin
          cnt_load  = 1'b1;
          cnt_value = word_beats;
          state_d   = ST_WAITBEAT;
        end else begin
          end_song = 1'b1;
        end
      end
      ST_ISSUE: begin
        last_note_d = pend_note_q;
        last_dur_d  = pend_dur_q;
        advance     = 1'b1;
      end
      ST_WAITBEAT: begin
        if (cnt_zero) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (advance) begin
      if (index_q == '1) begin
        end_song = 1'b1;
      end else begin
        index_d = index_q + 1'b1;
        state_d = ST_FETCH;
      end
    end

    if (end_song) begin
`ifdef SONG_SEQUENCER_LOOP_EN
      index_d = '0;
      state_d = ST_FETCH;
      done_d  = 1'b1;
`else
      state_d = ST_DONE;
      done_d  = 1'b1;
`endif
    end

    // Song change overrides everything; the suppressed strobe must not
    // update the held note/duration either.
    if (song_chg) begin
      index_d     = '0;
      state_d     = ST_FETCH;
      done_d      = 1'b0;
      cnt_load    = 1'b1;
      cnt_value   = '0;
      last_note_d = last_note_q;
      last_dur_d  = last_dur_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      index_q     <= '0;
      song_q      <= song;
      done_q      <= 1'b0;
      pend_note_q <= '0;
      pend_dur_q  <= '0;
      last_note_q <= '0;
      last_dur_q  <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      song_q      <= song_d;
      done_q      <= done_d;
      pend_note_q <= pend_note_d;
      pend_dur_q  <= pend_dur_d;
      last_note_q <= last_note_d;
      last_dur_q  <= last_dur_d;
    end
  end

  assign rom_addr         = {song, index_q};
  assign load_new_note    = issue_fire;
  assign note_to_load     = issue_fire ? pend_note_q : last_note_q;
  assign duration_to_load = issue_fire ? pend_dur_q  : last_dur_q;
  assign song_done        = done_q;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Drives the note-load side of the note distributor protocol; its outputs connect directly to the distributor's load_new_note, note_to_load and duration_to_load inputs.
- Steps through one song stored in an external synchronous song ROM.
- Note entries are issued as single-cycle load pulses. Consecutive note entries therefore start together as a chord.
- Wait entries stall the sequence for a number of beats. A zero wait, or running off the end of the song, ends the song.

Parameters:
- SONG_BITS, 2, width of the song select; 2^SONG_BITS songs.
- ENTRY_BITS, 5, entries per song = 2^ENTRY_BITS.
- ROM_WIDTH, 16, width of a ROM word.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- play  in  1  high = advance; low = pause.
- beat  in  1  single-cycle 48 Hz tick.
- song  in  SONG_BITS  song select.
- rom_addr  out  SONG_BITS+ENTRY_BITS  {song, index}.
- rom_data  in  ROM_WIDTH  ROM word, valid one cycle after rom_addr.
- load_new_note  out  1  single-cycle note-load strobe.
- note_to_load  out  6  note code, valid while load_new_note is high.
- duration_to_load  out  6  duration in beats, valid while load_new_note is high.
- song_done  out  1  song finished.

Behaviour:
- Reset values: load_new_note=0, note_to_load=0, duration_to_load=0, song_done=0, index=0, rom_addr={song,0}, state=FETCH.
- Entry format:
  - bit15=0: note entry; note=[14:9], duration=[8:3]; [2:0] ignored.
  - bit15=1: wait entry; beats=[5:0]; [14:6] ignored.
- States:
  - FETCH: present rom_addr={song,index}. If play=1, go to ROMWAIT; otherwise hold.
  - ROMWAIT: one cycle for ROM latency; go to DECODE.
  - DECODE: register the word, then:
    - note entry -> ISSUE.
    - wait entry with beats>0 -> load beat counter with beats, go to WAITBEAT.
    - wait entry with beats==0 -> DONE.
  - ISSUE: load_new_note=1 for exactly this cycle, with note/duration driven; index+1; go to FETCH.
  - WAITBEAT: each cycle with beat&&play, decrement the counter. When the counter reaches 0, index+1 and go to FETCH. If beat arrives with play=0, it is ignored.
  - DONE: song_done=1 (sticky); no strobes.
- Pulse spacing: at least 4 cycles between load_new_note strobes (FETCH→ROMWAIT→DECODE→ISSUE). The distributor's player arbitration needs this spacing to settle.
- note_to_load and duration_to_load hold their last issued values between strobes.
- End-of-table: incrementing index from 2^ENTRY_BITS-1 goes to DONE instead of wrapping.
- Song change: if song differs from its value registered on the previous cycle, then on the next cycle:
  - index=0, state=FETCH, song_done=0, counter cleared;
  - any strobe due that cycle is suppressed.
- play deasserted mid-note-chain: the FETCH gate stalls before the next fetch. An in-flight ROMWAIT/DECODE/ISSUE completes.
- beat coinciding with counter load in DECODE: ignored. Counting starts in WAITBEAT.
- Reset mid-operation: all state returns to reset values on the next edge; no strobe is emitted that cycle.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
- Defined: instead of entering DONE, return to index=0/FETCH. song_done pulses high for exactly one cycle on each wrap.
- Undefined: DONE is terminal and song_done is sticky until reset or song change.

Decomposition:
- Shared package music_pkg:
  - NOTE_W=6, DUR_W=6.
  - entry field bit positions.
  - ENTRY_NOTE/ENTRY_WAIT type constants.
  - state encoding localparams.
- Sub-module beat_countdown:
  - load, value, beat, play in; zero out.
  - 6-bit down-counter shared by this block and future tempo logic.

Test Plan:
- Song 0 = [note 12 dur 8, note 16 dur 8, wait 2, wait 0], play=1: two strobes carrying (12,8) then (16,8), exactly 4 cycles apart. After 2 beats, the next fetch reads address 3; song_done rises and no further strobes occur.
- Same song, play=0 during WAITBEAT with 3 beats applied: counter is unchanged. Raise play: exactly 2 more beats are needed.
- Switch song 0→2 mid-WAITBEAT: rom_addr reads {2,0} within 2 cycles, song_done=0, and the first strobe carries song 2's first entry.
- Song of 32 note entries with no wait: 32 strobes, then song_done=1 with no wrap. With SONG_SEQUENCER_LOOP_EN, strobe 33 carries entry 0 and song_done pulses high for one cycle.
- Assert reset in the ISSUE cycle: load_new_note=0 on that edge; all outputs return to reset values and rom_addr={song,0}.
- beat coincident with DECODE of wait 1: no decrement in that cycle; the next beat completes the wait.
